display_scan_controller: RTL
============================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed seven-segment digits, range 2..16.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit is lit per scan slot, minimum 2.
REQ-003 Parameter GAP_CYCLES, default 16: all-anodes-off dead time between slots, range 0..255; 0 means no gap.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 en  input  1: scan enable.
REQ-007 load  input  1: request to accept a new display word; transfers when load && ready.
REQ-008 data_in  input  4*NUM_DIGITS: hex nibbles; digit i = data_in[4i+3:4i]; digit 0 is least significant.
REQ-009 blank_mask  input  NUM_DIGITS: per-digit forced blank, captured together with data_in.
REQ-010 dp_mask  input  NUM_DIGITS: per-digit decimal point, captured together with data_in.
REQ-011 lz_en  input  1: leading-zero suppression, captured together with data_in.
REQ-012 ready  output  1: high when the pending register is empty.
REQ-013 digit_sel_n  output  NUM_DIGITS: active-low anode enables, one-hot-low or all ones.
REQ-014 nibble  output  4: hex value for the external seven-segment decoder.
REQ-015 dp_n  output  1: active-low decimal point for the selected digit.
REQ-016 frame_done  output  1: one-cycle pulse at each scan wrap.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Storage: pending register (data, masks, lz_en, pending_valid) and active register (same fields, active_valid).
REQ-019 Transfer on load && ready: capture into pending, set pending_valid, ready = 0 from the next cycle.
REQ-020 load while ready = 0 SHALL be ignored, leaving pending unchanged.
REQ-021 Commit copies pending to active, sets active_valid, clears pending_valid, and sets ready = 1 from the next cycle.
REQ-022 Commit occurs only in OFF, or at the wrap from digit NUM_DIGITS-1 to digit 0, so a frame is never torn.
REQ-023 States: OFF, SHOW, GAP. idx counts 0..NUM_DIGITS-1; slot counter counts 0..REFRESH_DIV-1; gap counter counts 0..GAP_CYCLES-1.
REQ-024 OFF: digit_sel_n = all ones, dp_n = 1, idx = 0.
REQ-025 OFF exit: when en = 1 and (active_valid or pending_valid), commit if pending_valid, then enter SHOW with idx 0.
REQ-026 SHOW: lasts exactly REFRESH_DIV cycles.
REQ-027 SHOW: nibble = active nibble idx.
REQ-028 SHOW: digit_sel_n[idx] = 0 unless digit idx is blanked.
REQ-029 SHOW: dp_n = ~active dp_mask[idx]; dp_n = 1 if the digit is blanked.
REQ-030 SHOW end, GAP_CYCLES > 0: enter GAP.
REQ-031 SHOW end, GAP_CYCLES = 0: advance directly per REQ-033.
REQ-032 GAP: digit_sel_n = all ones and dp_n = 1 for exactly GAP_CYCLES cycles, then advance.
REQ-033 Advance: idx+1, or wrap to 0 after NUM_DIGITS-1.
REQ-034 At wrap: pulse frame_done, commit if pending_valid, re-enter SHOW.
REQ-035 Digit i blanked = active blank_mask[i] = 1, or (active lz_en and i != 0 and all active nibbles i..NUM_DIGITS-1 == 0).
REQ-036 Digit 0 is never zero-suppressed.
REQ-037 A blanked digit SHALL keep its full slot timing.
REQ-038 en = 0 in SHOW or GAP: enter OFF on the next cycle; clear counters; keep active and pending contents.
REQ-039 load and commit in the same cycle: commit moves the old pending; ready is 0 that cycle, so the new load is not accepted.
REQ-040 Simultaneous en fall and wrap: OFF takes priority; commit still occurs; frame_done still pulses.

Reset
REQ-041 While rst = 1: state OFF, idx/slot/gap counters 0, pending_valid = 0, active_valid = 0.
REQ-042 While rst = 1: ready = 1, digit_sel_n = all ones, nibble = 0, dp_n = 1, frame_done = 0.
REQ-043 Reset asserted mid-scan SHALL force these values immediately, with no clock edge required.
REQ-044 Reset mid-scan SHALL discard pending and active data.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1)
REQ-045 rst=1, en=1, no load: digit_sel_n=1111, ready=1 indefinitely after rst release.
REQ-046 load data_in=16'h1234, masks 0, lz_en=0: digit_sel_n=1110 for 4 cycles, nibble=4; then 1111 for 1 cycle; then 1101 with nibble=3; frame_done every 20 cycles.
REQ-047 data_in=16'h0050, lz_en=1: digits 3 and 2 never lit; digit 1 lit with nibble 5; digit 0 lit with nibble 0.
REQ-048 Second load mid-frame: ready=0 until the wrap cycle; new value first shown in digit 0 slot after frame_done; a third load held high is accepted only after ready returns to 1.
REQ-049 en dropped during the digit 2 slot: all anodes off next cycle; on en re-raise, scan restarts at digit 0 with the same data.
REQ-050 rst pulsed mid-GAP: outputs return to reset values asynchronously; display stays dark after release until a new load.

Source files
------------

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// display_scan_controller: time-multiplexed seven-segment scan engine with a
// double-buffered display word, per-digit blanking and leading-zero suppression.
// Revision: 1.0
// ============================================================================
module display_scan_controller #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic [3:0]              nibble,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [7:0]          gap_q, gap_d;

  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                  act_lz_q, act_lz_d;
  logic                  act_valid_q, act_valid_d;

  logic                  ready_q, ready_d;
  logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  commit;
  logic                  advance;
  logic [NUM_DIGITS-1:0] blank;

  // Next-state, buffer transfer and commit logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    gap_d        = gap_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_blank_d  = act_blank_q;
    act_dp_d     = act_dp_q;
    act_lz_d     = act_lz_q;
    act_valid_d  = act_valid_q;
    frame_done_d = 1'b0;
    commit       = 1'b0;
    advance      = 1'b0;

    if (load && ready_q) begin
      pend_data_d  = data_in;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
      pend_lz_d    = lz_en;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        idx_d  = '0;
        slot_d = '0;
        gap_d  = '0;
        if (en && (act_valid_q || pend_valid_q)) begin
          commit  = pend_valid_q;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (advance) begin
      state_d = ST_SHOW;
      slot_d  = '0;
      gap_d   = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
        commit       = pend_valid_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Losing enable wins over the wrap, but the wrap's commit and pulse stand.
    if (state_q != ST_OFF && !en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      slot_d  = '0;
      gap_d   = '0;
    end

    if (commit) begin
      act_data_d   = pend_data_q;
      act_blank_d  = pend_blank_q;
      act_dp_d     = pend_dp_q;
      act_lz_d     = pend_lz_q;
      act_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
    end

    ready_d = ~pend_valid_d;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    assign blank[gi] = act_blank_d[gi] |
                       (act_lz_d & (gi != 0) & ((act_data_d >> (4 * gi)) == '0));
  end

  // Outputs are derived from the next state so they line up with state_q.
  always_comb begin
    digit_sel_n_d = '1;
    dp_n_d        = 1'b1;
    nibble_d      = 4'd0;
    if (state_d == ST_SHOW) begin
      nibble_d = act_data_d[{idx_d, 2'b00} +: 4];
      if (!blank[idx_d]) begin
        digit_sel_n_d[idx_d] = 1'b0;
        dp_n_d               = ~act_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      idx_q         <= '0;
      slot_q        <= '0;
      gap_q         <= '0;
      pend_data_q   <= '0;
      pend_blank_q  <= '0;
      pend_dp_q     <= '0;
      pend_lz_q     <= 1'b0;
      pend_valid_q  <= 1'b0;
      act_data_q    <= '0;
      act_blank_q   <= '0;
      act_dp_q      <= '0;
      act_lz_q      <= 1'b0;
      act_valid_q   <= 1'b0;
      ready_q       <= 1'b1;
      digit_sel_n_q <= '1;
      nibble_q      <= 4'd0;
      dp_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      gap_q         <= gap_d;
      pend_data_q   <= pend_data_d;
      pend_blank_q  <= pend_blank_d;
      pend_dp_q     <= pend_dp_d;
      pend_lz_q     <= pend_lz_d;
      pend_valid_q  <= pend_valid_d;
      act_data_q    <= act_data_d;
      act_blank_q   <= act_blank_d;
      act_dp_q      <= act_dp_d;
      act_lz_q      <= act_lz_d;
      act_valid_q   <= act_valid_d;
      ready_q       <= ready_d;
      digit_sel_n_q <= digit_sel_n_d;
      nibble_q      <= nibble_d;
      dp_n_q        <= dp_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign ready       = ready_q;
  assign digit_sel_n = digit_sel_n_q;
  assign nibble      = nibble_q;
  assign dp_n        = dp_n_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire
